// File: rtl/bus_pkg.sv
// Shared defaults and types for the valid/ready bus
// interface, its checker and the bus_if top.
package bus_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;
  typedef logic [DATA_W_DEF-1:0] data_t;
endpackage

// File: rtl/bus_chan.sv
// Valid/ready channel bundle with master, slave
// and monitor views.
interface bus_chan #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              xfer;
  logic [DATA_W-1:0] last_data;
  logic [CNT_W-1:0]  xfer_count;
  logic              err_drop;
  logic              err_unstable;

  assign xfer = valid & ready;

  modport master (
    input  clk, rst, ready,
    output data, valid
  );

  modport slave (
    input  clk, rst, data, valid,
    output ready
  );

  modport monitor (
    input clk, rst, data, valid, ready, xfer,
          last_data, xfer_count,
          err_drop, err_unstable
  );
endinterface

// File: rtl/bus_if_checker.sv
// Passive transfer counter and protocol checker;
// only observes the channel through its monitor view.
module bus_if_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  bus_chan.monitor          bus,
  output logic [DATA_W-1:0] last_data,
  output logic [CNT_W-1:0]  xfer_count,
  output logic              err_drop,
  output logic              err_unstable
);
  logic              prev_valid;
  logic              prev_ready;
  logic [DATA_W-1:0] prev_data;
  logic              stalled;
  logic              drop_now;
  logic              unstable_now;

  // a beat offered last edge but not taken
  assign stalled      = prev_valid & ~prev_ready;
  assign drop_now     = stalled & ~bus.valid;
  assign unstable_now = stalled & bus.valid &
                        (bus.data != prev_data);

  always_ff @(posedge bus.clk or posedge bus.rst) begin
    if (bus.rst) begin
      prev_valid <= 1'b0;
      prev_ready <= 1'b0;
      prev_data  <= '0;
    end else begin
      prev_valid <= bus.valid;
      prev_ready <= bus.ready;
      prev_data  <= bus.data;
    end
  end

  always_ff @(posedge bus.clk or posedge bus.rst) begin
    if (bus.rst) begin
      last_data  <= '0;
      xfer_count <= '0;
    end else if (bus.xfer) begin
      last_data  <= bus.data;
      xfer_count <= xfer_count + 1'b1;
    end
  end

  always_ff @(posedge bus.clk or posedge bus.rst) begin
    if (bus.rst) begin
      err_drop     <= 1'b0;
      err_unstable <= 1'b0;
    end else begin
      if (drop_now)     err_drop     <= 1'b1;
      if (unstable_now) err_unstable <= 1'b1;
    end
  end
endmodule

// File: rtl/bus_if.sv
// Bus channel wrapper: carries the external beat into
// the channel and exposes the checker's view.
module bus_if
  import bus_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  input  logic              ready,
  output logic              xfer,
  output logic [DATA_W-1:0] last_data,
  output logic [CNT_W-1:0]  xfer_count,
  output logic              err_drop,
  output logic              err_unstable
);
  logic [DATA_W-1:0] chk_last;
  logic [CNT_W-1:0]  chk_count;
  logic              chk_drop;
  logic              chk_unstable;

  bus_chan #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) bus (
    .clk(clk),
    .rst(rst)
  );

  assign bus.data         = data;
  assign bus.valid        = valid;
  assign bus.ready        = ready;
  assign bus.last_data    = chk_last;
  assign bus.xfer_count   = chk_count;
  assign bus.err_drop     = chk_drop;
  assign bus.err_unstable = chk_unstable;

  bus_if_checker #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_chk (
    .bus         (bus.monitor),
    .last_data   (chk_last),
    .xfer_count  (chk_count),
    .err_drop    (chk_drop),
    .err_unstable(chk_unstable)
  );

  assign xfer         = bus.xfer;
  assign last_data    = bus.last_data;
  assign xfer_count   = bus.xfer_count;
  assign err_drop     = bus.err_drop;
  assign err_unstable = bus.err_unstable;
endmodule

// File: tb/tb_bus_if.sv
// Self-checking bench for bus_if: vector table,
// directed corner sequences and random vs. model.
module tb_bus_if;
  import bus_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int CW = CNT_W_DEF;

  logic          clk = 1'b0;
  logic          rst;
  data_t         data;
  logic          valid;
  logic          ready;
  logic          xfer;
  data_t         last_data;
  logic [CW-1:0] xfer_count;
  logic          err_drop;
  logic          err_unstable;

  int tests  = 0;
  int failed = 0;

  bus_if #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .xfer        (xfer),
    .last_data   (last_data),
    .xfer_count  (xfer_count),
    .err_drop    (err_drop),
    .err_unstable(err_unstable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        r;
    logic [7:0]  d;
    logic        x;
    logic [7:0]  last;
    int          cnt;
    logic        drop;
    logic        unst;
  } vec_t;

  vec_t vecs[$];

  // behavioural reference
  int          m_cnt;
  logic [7:0]  m_last;
  logic        m_drop, m_unst;
  bit          m_pend;
  logic [7:0]  m_pend_d;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_last = '0;
    m_drop = 0; m_unst = 0; m_pend = 0;
    m_pend_d = '0;
  endtask

  // a beat is "pending" when offered and refused
  task automatic model_edge(input logic v,
                            input logic r,
                            input logic [7:0] d);
    if (m_pend && !v) m_drop = 1;
    if (m_pend && v && d != m_pend_d) m_unst = 1;
    if (v && r) begin
      m_last = d;
      m_cnt  = (m_cnt + 1) % (1 << CW);
    end
    m_pend   = v && !r;
    m_pend_d = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic v, input logic r,
                      input logic [7:0] d);
    valid = v; ready = r; data = d;
    model_edge(v, r, d);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".last"}, 32'(last_data), 32'(m_last));
    chk({tag, ".cnt"}, 32'(xfer_count), 32'(m_cnt));
    chk({tag, ".drop"}, 32'(err_drop), 32'(m_drop));
    chk({tag, ".unst"}, 32'(err_unstable), 32'(m_unst));
  endtask

  initial begin
    valid = 0; ready = 0; data = '0;
    rst = 1'b1;
    model_reset();
    #3;
    chk("reset.last", 32'(last_data), 0);
    chk("reset.cnt", 32'(xfer_count), 0);
    chk("reset.drop", 32'(err_drop), 0);
    chk("reset.unst", 32'(err_unstable), 0);
    do_reset();

    // v r d | xfer last cnt drop unst
    vecs.push_back('{1,1,8'hAB, 1,8'hAB,1,0,0});
    vecs.push_back('{1,0,8'h11, 0,8'hAB,1,0,0});
    vecs.push_back('{1,0,8'h11, 0,8'hAB,1,0,0});
    vecs.push_back('{1,0,8'h11, 0,8'hAB,1,0,0});
    vecs.push_back('{1,1,8'h11, 1,8'h11,2,0,0});
    vecs.push_back('{0,1,8'h55, 0,8'h11,2,0,0});
    vecs.push_back('{1,1,8'h22, 1,8'h22,3,0,0});
    vecs.push_back('{1,1,8'h33, 1,8'h33,4,0,0});
    vecs.push_back('{0,0,8'h44, 0,8'h33,4,0,0});
    vecs.push_back('{1,1,8'h66, 1,8'h66,5,0,0});
    foreach (vecs[i]) begin
      valid = vecs[i].v;
      ready = vecs[i].r;
      data  = vecs[i].d;
      #1;
      chk($sformatf("vec%0d.xfer", i),
          32'(xfer), 32'(vecs[i].x));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.last", i),
          32'(last_data), 32'(vecs[i].last));
      chk($sformatf("vec%0d.cnt", i),
          32'(xfer_count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d.drop", i),
          32'(err_drop), 32'(vecs[i].drop));
      chk($sformatf("vec%0d.unst", i),
          32'(err_unstable), 32'(vecs[i].unst));
    end

    // data changes while stalled
    valid = 0; ready = 0;
    do_reset();
    step(1, 0, 8'h11);
    step(1, 0, 8'h22);
    chk("unstable.flag", 32'(err_unstable), 1);
    chk("unstable.drop", 32'(err_drop), 0);
    step(0, 0, 8'h22);
    chk("unstable.sticky", 32'(err_unstable), 1);

    // valid dropped before acceptance
    valid = 0;
    do_reset();
    step(1, 1, 8'h01);
    step(1, 0, 8'h02);
    step(0, 0, 8'h02);
    chk("drop.flag", 32'(err_drop), 1);
    chk("drop.cnt", 32'(xfer_count), 1);
    chk("drop.unst", 32'(err_unstable), 0);
    step(1, 1, 8'h03);
    chk("drop.sticky", 32'(err_drop), 1);

    // reset in the middle of a stall
    valid = 0;
    do_reset();
    step(1, 0, 8'h77);
    step(1, 0, 8'h77);
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    valid = 0; ready = 0; data = 8'h99;
    rst = 1'b0;
    model_reset();
    step(0, 0, 8'h99);
    chk("stallrst.drop", 32'(err_drop), 0);
    chk("stallrst.unst", 32'(err_unstable), 0);

    // counter wrap: 2^CW + 1 beats
    do_reset();
    valid = 1; ready = 1;
    for (int i = 0; i < (1 << CW) + 1; i++) begin
      data = 8'(i);
      @(posedge clk);
      #1;
    end
    valid = 0;
    chk("wrap.cnt", 32'(xfer_count), 1);
    chk("wrap.last", 32'(last_data), 0);

    // asynchronous reset mid-stream
    valid = 1; ready = 1; data = 8'h5A;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst.cnt", 32'(xfer_count), 0);
    chk("midrst.last", 32'(last_data), 0);
    chk("midrst.drop", 32'(err_drop), 0);
    chk("midrst.unst", 32'(err_unstable), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(1, 1, 8'hC1);
    step(1, 1, 8'hC2);
    chk("midrst.resume", 32'(xfer_count), 2);
    chk("midrst.rlast", 32'(last_data), 32'hC2);

    // random traffic against the reference model
    valid = 0; ready = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic       v, r;
      logic [7:0] d;
      v = 1'($urandom_range(0, 3) != 0);
      r = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 7) == 0)
          ? 8'($urandom) : data;
      if (i % 100 == 99) begin
        valid = 0;
        do_reset();
      end
      step(v, r, d);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, failed);
    $finish;
  end
endmodule
